// File: rtl/data_mem_responder.sv
// data_mem_responder: memory end of the core's M-stage load/store interface
//
// Serves one load or store at a time from a 2^ADDR_W x 32-bit word array,
// waits WAIT_CYCLES cycles, then raises a one-cycle response strobe.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   req_valid  M stage presents a request
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     store byte enables (only with DMEM_BYTE_EN defined)
//   req_ready  a request can be accepted this cycle
//   resp_valid one-cycle response strobe
//   resp_rdata load data; 0 for stores and errors
//   resp_err   misaligned or out-of-range access
//   stall_req  core must hold its F/D/E/M stages
//
// Build option: define DMEM_BYTE_EN to add per-byte store enables.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]        req_be,
`endif
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall_req
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    // With no wait states the access happens at the accepting edge,
    // straight from the request inputs rather than the captured copies.
    localparam bit ZW = (WAIT_CYCLES == 0);
    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                resp_valid_q;
    logic                resp_err_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic                acc;
    logic                acc_we;
    logic [31:0]         acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_err;
    logic [ADDR_W-1:0]   acc_idx;
`ifdef DMEM_BYTE_EN
    logic [3:0]          be_q;
    logic [3:0]          acc_be;
`endif
    always_comb begin
        acc       = !reset && (ZW ? (state_q == IDLE && req_valid)
                                  : (state_q == WAIT && cnt_q == 4'd1));
        acc_we    = ZW ? req_we    : we_q;
        acc_addr  = ZW ? req_addr  : addr_q;
        acc_wdata = ZW ? req_wdata : wdata_q;
        acc_err   = (|acc_addr[1:0]) || (|acc_addr[31:ADDR_W+2]);
        acc_idx   = acc_addr[ADDR_W+1:2];
`ifdef DMEM_BYTE_EN
        acc_be    = ZW ? req_be : be_q;
`endif
    end
    assign req_ready  = !reset && state_q == IDLE;
    assign stall_req  = !reset && ((state_q == IDLE && req_valid) || state_q == WAIT);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= '0;
`ifdef DMEM_BYTE_EN
            be_q         <= 4'd0;
`endif
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= acc;
            if (acc) begin
                resp_err_q   <= acc_err;
                resp_rdata_q <= (acc_err || acc_we) ? '0 : mem[acc_idx];
            end
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
`ifdef DMEM_BYTE_EN
                    be_q    <= req_be;
`endif
                    cnt_q   <= 4'(WAIT_CYCLES);
                    state_q <= ZW ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Array is deliberately not reset; acc is already gated by reset so an
    // aborted store never commits.
    always_ff @(posedge clk) begin
        if (acc && acc_we && !acc_err) begin
`ifdef DMEM_BYTE_EN
            for (int b = 0; b < DATA_W / 8; b++)
                if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
`else
            mem[acc_idx] <= acc_wdata;
`endif
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder at 2 and 0 wait states
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v2 = 1'b0, v0 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = 4'hF;
    logic        rdy2, rv2, err2, st2, rdy0, rv0, err0, st0;
    logic [31:0] rd2, rd0;
    logic        sel = 1'b0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_we(we), .req_addr(addr),
        .req_wdata(wdata),
`ifdef DMEM_BYTE_EN
        .req_be(be),
`endif
        .req_ready(rdy2), .resp_valid(rv2), .resp_rdata(rd2), .resp_err(err2),
        .stall_req(st2));

    data_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_we(we), .req_addr(addr),
        .req_wdata(wdata),
`ifdef DMEM_BYTE_EN
        .req_be(be),
`endif
        .req_ready(rdy0), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0),
        .stall_req(st0));

    wire        m_rdy = sel ? rdy0 : rdy2;
    wire        m_rv  = sel ? rv0  : rv2;
    wire        m_err = sel ? err0 : err2;
    wire        m_st  = sel ? st0  : st2;
    wire [31:0] m_rd  = sel ? rd0  : rd2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for IDLE, presents one request, returns the response, the number
    // of edges from acceptance to the response and the cycles stall_req was high.
    task automatic xfer(input logic s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic e,
                        output int lat, output int stalls);
        int n;
        sel = s;
        n = 0;
        #1;
        while (!m_rdy && n < 20) begin
            @(posedge clk); #1; n++;
        end
        we = w; addr = a; wdata = d; be = b;
        v2 = !s; v0 = s;
        #1;
        stalls = int'(m_st);
        @(posedge clk); #1;
        v2 = 1'b0; v0 = 1'b0;
        lat = 0;
        while (!m_rv && lat < 20) begin
            stalls += int'(m_st);
            @(posedge clk); #1; lat++;
        end
        rd = m_rd;
        e = m_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, stalls, hits;
        logic [5:0]  pat;
        #12 #1;
        check("rst_ready", {31'd0, rdy2}, 32'd0);
        check("rst_rv", {31'd0, rv2}, 32'd0);
        check("rst_rdata", rd2, 32'd0);
        check("rst_err", {31'd0, err2}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        check("idle_ready", {31'd0, rdy2}, 32'd1);
        check("idle_stall", {31'd0, st2}, 32'd0);

        xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, stalls);
        check("st_lat", lat, 2);
        check("st_stalls", stalls, 3);
        check("st_err", {31'd0, e}, 32'd0);
        check("st_rdata", rd, 32'd0);
        check("st_resp_stall", {31'd0, m_st}, 32'd0);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat, stalls);
        check("ld_rdata", rd, 32'hDEADBEEF);
        check("ld_err", {31'd0, e}, 32'd0);
        check("ld_lat", lat, 2);
        @(posedge clk); #1;
        check("ld_hold_rv", {31'd0, rv2}, 32'd0);
        check("ld_hold_rdata", rd2, 32'hDEADBEEF);

        xfer(1'b0, 1'b1, 32'h13, 32'h12345678, 4'hF, rd, e, lat, stalls);
        check("mis_err", {31'd0, e}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat, stalls);
        check("mis_nowrite", rd, 32'hDEADBEEF);
        xfer(1'b0, 1'b0, 32'h1000, 32'h0, 4'hF, rd, e, lat, stalls);
        check("oor_err", {31'd0, e}, 32'd1);
        check("oor_rdata", rd, 32'd0);
        xfer(1'b0, 1'b0, 32'hFFC, 32'h0, 4'hF, rd, e, lat, stalls);
        check("top_err", {31'd0, e}, 32'd0);

        xfer(1'b1, 1'b1, 32'h0, 32'd7, 4'hF, rd, e, lat, stalls);
        check("z_st_lat", lat, 0);
        check("z_st_stalls", stalls, 1);
        xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat, stalls);
        check("z_ld_rdata", rd, 32'd7);
        check("z_ld_lat", lat, 0);
        @(posedge clk); #1;
        we = 1'b0; addr = 32'h0; v0 = 1'b1;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat = {pat[4:0], rv0};
        end
        v0 = 1'b0;
        check("z_b2b_pattern", {26'd0, pat}, 32'h2A);

        xfer(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, rd, e, lat, stalls);
        sel = 1'b0;
        @(posedge clk); #1;
        we = 1'b1; addr = 32'h20; wdata = 32'h55; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_rv", {31'd0, rv2}, 32'd0);
        check("mid_rst_stall", {31'd0, st2}, 32'd0);
        check("mid_rst_ready", {31'd0, rdy2}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            #1 hits += int'(rv2);
            @(posedge clk); #1;
        end
        check("abort_no_resp", hits, 0);
        check("abort_ready", {31'd0, rdy2}, 32'd1);
        xfer(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat, stalls);
        check("abort_nowrite", rd, 32'h0);

        xfer(1'b0, 1'b1, 32'h8, 32'h11223344, 4'hF, rd, e, lat, stalls);
        xfer(1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd, e, lat, stalls);
        xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, rd, e, lat, stalls);
`ifdef DMEM_BYTE_EN
        check("be_merge", rd, 32'h11BB33DD);
        xfer(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, rd, e, lat, stalls);
        check("be_zero_err", {31'd0, e}, 32'd0);
        xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, rd, e, lat, stalls);
        check("be_zero_nowrite", rd, 32'h11BB33DD);
`else
        check("full_word", rd, 32'hAABBCCDD);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
